synapse_seq: RTL and testbench

//  Sequencer for one Synapse tile. Holds a small program of configuration words and steps through them.

---
 rtl/synapse_seq.sv | 142 ++++++++++++++
 tb/tb_synapse_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_seq.sv
// Program sequencer for one Synapse tile: steps PMEM entries, one MAC pass (FETCH, RUN, DRAIN, WRITE) per entry.
// Latency vec_len+4 cycles per entry, done one cycle after the last WRITE; no backpressure, abort cancels at any time.
module synapse_seq #(
   parameter int ADDR_DMEM = 8,
   parameter int ADDR_CMEM = 4,
   parameter int CONF_W    = 15,
   parameter int LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [ADDR_CMEM-1:0] cfg_waddr,
   input  logic [CONF_W-1:0]    cfg_wdata,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_CMEM-1:0] prog_base,
   input  logic [LEN_W-1:0]     prog_len,
   input  logic [LEN_W-1:0]     vec_len,
   input  logic [ADDR_DMEM-1:0] r_base,
   input  logic [ADDR_DMEM-1:0] w_base,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CONF_W-1:0]    conf,
   output logic [ADDR_DMEM-1:0] r_addr,
   output logic [ADDR_DMEM-1:0] w_addr,
   output logic                 we_ram
);

   typedef enum logic [2:0] {IDLE, FETCH, RUN, DRAIN, WRITE} state_t;

   typedef struct packed {
      logic [LEN_W-1:0]     prog_len;
      logic [LEN_W-1:0]     vec_len;
      logic [ADDR_DMEM-1:0] r_base;
      logic [ADDR_DMEM-1:0] w_base;
   } launch_t;

   state_t                 state, state_nxt;
   launch_t                lch;
   logic [CONF_W-1:0]      pmem [0:2**ADDR_CMEM-1];
   logic [ADDR_CMEM-1:0]   ptr;
   logic [LEN_W-1:0]       idx;
   logic [LEN_W-1:0]       k;
   logic                   dcnt;
   logic [LEN_W:0]         idx_nxt;
   logic [LEN_W-1:0]       vec_last;
   logic                   start_bad;
   logic                   last_entry;

   assign busy       = (state != IDLE);
   assign we_ram     = (state == WRITE);
   assign start_bad  = (prog_len == '0) || (vec_len == '0);
   assign idx_nxt    = {1'b0, idx} + (LEN_W+1)'(1);
   assign last_entry = (idx_nxt >= {1'b0, lch.prog_len});
   assign vec_last   = lch.vec_len - LEN_W'(1);

   // Program memory is deliberately left out of reset so a loaded program survives it.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy)
         pmem[cfg_waddr] <= cfg_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !abort && !start_bad) state_nxt = FETCH;
         FETCH:   state_nxt = RUN;
         RUN:     if (k == vec_last) state_nxt = DRAIN;
         DRAIN:   if (dcnt) state_nxt = WRITE;
         WRITE:   state_nxt = last_entry ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lch    <= '0;
         ptr    <= '0;
         idx    <= '0;
         k      <= '0;
         dcnt   <= 1'b0;
         conf   <= '0;
         r_addr <= '0;
         w_addr <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= cfg_we && busy;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if (start_bad) begin
                     err <= 1'b1;
                  end else begin
                     lch <= '{prog_len: prog_len, vec_len: vec_len, r_base: r_base, w_base: w_base};
                     ptr <= prog_base;
                     idx <= '0;
                  end
               end
            end
            FETCH: begin
               conf   <= pmem[ptr];
               r_addr <= lch.r_base;
               k      <= '0;
               dcnt   <= 1'b0;
            end
            RUN: begin
               if (k != vec_last) begin
                  r_addr <= r_addr + ADDR_DMEM'(1);
                  k      <= k + LEN_W'(1);
               end
            end
            DRAIN: begin
               dcnt <= 1'b1;
               if (dcnt)
                  w_addr <= lch.w_base + ADDR_DMEM'(idx);
            end
            WRITE: begin
               idx <= idx + LEN_W'(1);
               ptr <= ptr + ADDR_CMEM'(1);
               if (last_entry && !abort)
                  done <= 1'b1;
            end
            default: ;
         endcase
         if (abort && state != IDLE)
            conf <= '0;
      end
   end

endmodule

// File: tb/tb_synapse_seq.sv
// Directed bench for synapse_seq: cycle-by-cycle checks of single, wrapping, rejected, aborted and back-to-back runs.
module tb_synapse_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_waddr;
   logic [14:0] cfg_wdata;
   logic        start;
   logic        abort;
   logic [3:0]  prog_base;
   logic [7:0]  prog_len;
   logic [7:0]  vec_len;
   logic [7:0]  r_base;
   logic [7:0]  w_base;
   logic        busy;
   logic        done;
   logic        err;
   logic [14:0] conf;
   logic [7:0]  r_addr;
   logic [7:0]  w_addr;
   logic        we_ram;

   int vecs = 0;
   int miscompares = 0;

   synapse_seq dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
      .start(start), .abort(abort), .prog_base(prog_base), .prog_len(prog_len),
      .vec_len(vec_len), .r_base(r_base), .w_base(w_base), .busy(busy), .done(done),
      .err(err), .conf(conf), .r_addr(r_addr), .w_addr(w_addr), .we_ram(we_ram)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [3:0] pb, input logic [7:0] pl, input logic [7:0] vl,
                         input logic [7:0] rb, input logic [7:0] wb);
      prog_base = pb; prog_len = pl; vec_len = vl; r_base = rb; w_base = wb;
      start = 1'b1;
   endtask

   task automatic write_pmem(input logic [3:0] a, input logic [14:0] d);
      cfg_waddr = a; cfg_wdata = d; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   // Clocks a launched run until done (bounded); cycle 1 is the cycle after start is sampled.
   task automatic measure(output int done_cyc, output int we_cyc, output int we_cnt);
      done_cyc = -1; we_cyc = -1; we_cnt = 0;
      for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
         tick();
         start = 1'b0;
         if (we_ram) begin
            we_cnt++;
            if (we_cyc < 0) we_cyc = c;
         end
         if (done) done_cyc = c;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0; start = 1'b0; abort = 1'b0;
      prog_base = '0; prog_len = '0; vec_len = '0; r_base = '0; w_base = '0;
      #2 rst = 1'b0;
      #1;
      vecs++;
      if ({busy, done, err, we_ram} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: busy/done/err/we_ram = %b, required 0000", {busy, done, err, we_ram});
      end
      vecs++;
      if ({conf, r_addr, w_addr} !== 31'h0) begin
         miscompares++;
         $display("FAIL reset_data: conf=%h r_addr=%h w_addr=%h, required all 0", conf, r_addr, w_addr);
      end
      tick();
      rst = 1'b1;
      tick();
      vecs++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_single();
      logic [7:0] ra [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
      write_pmem(4'd3, 15'h1A5);
      launch(4'd3, 8'd1, 8'd4, 8'h10, 8'h40);
      tick();
      start = 1'b0;
      vecs++;
      if (busy !== 1'b1 || we_ram !== 1'b0) begin
         miscompares++;
         $display("FAIL single_fetch: busy=%b we_ram=%b, required 1 0", busy, we_ram);
      end
      for (int c = 2; c <= 5; c++) begin
         tick();
         vecs++;
         if (conf !== 15'h1A5 || r_addr !== ra[c-2] || we_ram !== 1'b0) begin
            miscompares++;
            $display("FAIL single_run c%0d: conf=%h r_addr=%h we=%b, required 1a5 %h 0", c, conf, r_addr, we_ram, ra[c-2]);
         end
      end
      for (int c = 6; c <= 7; c++) begin
         tick();
         vecs++;
         if (r_addr !== 8'h13 || we_ram !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain c%0d: r_addr=%h we=%b done=%b, required 13 0 0", c, r_addr, we_ram, done);
         end
      end
      tick();
      vecs++;
      if (we_ram !== 1'b1 || w_addr !== 8'h40) begin
         miscompares++;
         $display("FAIL single_write: we=%b w_addr=%h, required 1 40", we_ram, w_addr);
      end
      tick();
      vecs++;
      if (done !== 1'b1 || busy !== 1'b0 || we_ram !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: done=%b busy=%b we=%b, required 1 0 0", done, busy, we_ram);
      end
      tick();
      vecs++;
      if (done !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done_pulse: done=%b err=%b, required 0 0", done, err);
      end
   endtask

   task automatic test_wrap();
      logic [7:0]  ra [3] = '{8'hFE, 8'hFF, 8'h00};
      logic [14:0] cf [2] = '{15'h7AB, 15'h0C3};
      logic [7:0]  wa [2] = '{8'h20, 8'h21};
      write_pmem(4'd15, 15'h7AB);
      write_pmem(4'd0, 15'h0C3);
      launch(4'd15, 8'd2, 8'd3, 8'hFE, 8'h20);
      for (int c = 1; c <= 14; c++) begin
         int pos = (c - 1) % 7;
         int ent = (c - 1) / 7;
         tick();
         start = 1'b0;
         if (pos >= 1 && pos <= 3) begin
            vecs++;
            if (conf !== cf[ent] || r_addr !== ra[pos-1]) begin
               miscompares++;
               $display("FAIL wrap_run c%0d: conf=%h r_addr=%h, required %h %h", c, conf, r_addr, cf[ent], ra[pos-1]);
            end
         end else if (pos == 6) begin
            vecs++;
            if (we_ram !== 1'b1 || w_addr !== wa[ent]) begin
               miscompares++;
               $display("FAIL wrap_write c%0d: we=%b w_addr=%h, required 1 %h", c, we_ram, w_addr, wa[ent]);
            end
         end else begin
            vecs++;
            if (we_ram !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL wrap_idle c%0d: we=%b done=%b busy=%b, required 0 0 1", c, we_ram, done, busy);
            end
         end
      end
      tick();
      vecs++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_done: done=%b busy=%b, required 1 0", done, busy);
      end
   endtask

   task automatic test_rejects();
      int dc, wc, wn;
      launch(4'd0, 8'd0, 8'd4, 8'h00, 8'h00);
      tick();
      start = 1'b0;
      vecs++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reject_plen: err=%b busy=%b, required 1 0", err, busy);
      end
      tick();
      vecs++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reject_plen_after: err=%b busy=%b, required 0 0", err, busy);
      end
      launch(4'd0, 8'd2, 8'd0, 8'h00, 8'h00);
      tick();
      start = 1'b0;
      vecs++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reject_vlen: err=%b busy=%b, required 1 0", err, busy);
      end
      write_pmem(4'd5, 15'h111);
      launch(4'd5, 8'd1, 8'd6, 8'h00, 8'h00);
      tick();
      start = 1'b0;
      cfg_waddr = 4'd5; cfg_wdata = 15'h555; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      vecs++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL reject_cfg_busy: err=%b, required 1", err);
      end
      measure(dc, wc, wn);
      vecs++;
      if (dc < 0) begin
         miscompares++;
         $display("FAIL reject_run_timeout: done never seen, required done");
      end
      launch(4'd5, 8'd1, 8'd1, 8'h00, 8'h00);
      tick();
      start = 1'b0;
      tick();
      vecs++;
      if (conf !== 15'h111) begin
         miscompares++;
         $display("FAIL reject_pmem_kept: conf=%h, required 111", conf);
      end
      measure(dc, wc, wn);
   endtask

   task automatic test_reset_midrun();
      int bad = 0;
      launch(4'd3, 8'd1, 8'd4, 8'h10, 8'h40);
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      vecs++;
      if (busy !== 1'b0 || we_ram !== 1'b0 || conf !== 15'h0 || r_addr !== 8'h00) begin
         miscompares++;
         $display("FAIL midrun_reset: busy=%b we=%b conf=%h r_addr=%h, required 0 0 0 0", busy, we_ram, conf, r_addr);
      end
      tick();
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (busy || done || we_ram) bad++;
      end
      vecs++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL midrun_after: %0d active cycles, required 0", bad);
      end
   endtask

   task automatic test_abort();
      int bad = 0;
      int dc, wc, wn;
      launch(4'd0, 8'd3, 8'd4, 8'h30, 8'h50);
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vecs++;
      if (busy !== 1'b0 || we_ram !== 1'b0 || conf !== 15'h0) begin
         miscompares++;
         $display("FAIL abort_next: busy=%b we=%b conf=%h, required 0 0 0", busy, we_ram, conf);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (busy || done || we_ram) bad++;
      end
      vecs++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL abort_quiet: %0d active cycles, required 0", bad);
      end
      launch(4'd3, 8'd1, 8'd4, 8'h10, 8'h40);
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      vecs++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_beats_start: busy=%b err=%b, required 0 0", busy, err);
      end
      launch(4'd3, 8'd1, 8'd4, 8'h10, 8'h40);
      measure(dc, wc, wn);
      vecs++;
      if (dc != 9 || wc != 8 || wn != 1) begin
         miscompares++;
         $display("FAIL abort_restart: done@%0d we@%0d we_cnt=%0d, required 9 8 1", dc, wc, wn);
      end
   endtask

   task automatic test_back_to_back();
      int d1, w1, n1, d2, w2, n2;
      launch(4'd3, 8'd1, 8'd4, 8'h10, 8'h40);
      measure(d1, w1, n1);
      vecs++;
      if (d1 != 9 || w1 != 8 || n1 != 1) begin
         miscompares++;
         $display("FAIL b2b_first: done@%0d we@%0d we_cnt=%0d, required 9 8 1", d1, w1, n1);
      end
      launch(4'd3, 8'd1, 8'd4, 8'h10, 8'h40);
      measure(d2, w2, n2);
      vecs++;
      if (d2 != 9 || w2 != 8 || n2 != 1) begin
         miscompares++;
         $display("FAIL b2b_second: done@%0d we@%0d we_cnt=%0d, required 9 8 1", d2, w2, n2);
      end
      vecs++;
      if (w_addr !== 8'h40 || conf !== 15'h1A5) begin
         miscompares++;
         $display("FAIL b2b_data: w_addr=%h conf=%h, required 40 1a5", w_addr, conf);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_rejects();
      test_reset_midrun();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
